// File: rtl/arith_pkg.sv
// Shared types and sizing helpers for the divide/mod arithmetic datapaths.
// The modulus and reconstruction units both use these, so one controller can drive either.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_WIDTH = cnt_width(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/recon_step.sv
// One shift-and-add iteration of Q*B+R: conditionally add the multiplicand, then shift.
// Purely combinational so a wider variant can chain several per clock.
module recon_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [2*WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0]   mplier_next
);

    // The accumulator is double width, so the add never drops a carry.
    always_comb begin
        acc_next    = mplier[0] ? (acc + mcand) : acc;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
    end

endmodule

// File: rtl/divmod_recon_dp.sv
// Reconstructs A = Q*B + R one multiplier bit per clock, flagging overflow and R >= B.
// Uses the same start/busy/done handshake as the repeated-subtraction modulus datapath.
module divmod_recon_dp
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             rem_err
);

    localparam int CNT_W = (WIDTH == DEFAULT_WIDTH) ? CNT_WIDTH : cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CNT_W-1:0]     cnt;
    logic                 rem_err_pend;

    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   mcand_step;
    logic [WIDTH-1:0]     mplier_step;

    recon_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_step),
        .mcand_next  (mcand_step),
        .mplier_next (mplier_step)
    );

    // Fixed WIDTH iterations with no early exit, so latency never depends on the operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            cnt          <= '0;
            rem_err_pend <= 1'b0;
            result       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            rem_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc          <= {{WIDTH{1'b0}}, R};
                        mcand        <= {{WIDTH{1'b0}}, B};
                        mplier       <= Q;
                        cnt          <= '0;
                        rem_err_pend <= (R >= B);
                        busy         <= 1'b1;
                        state        <= ADD;
                    end
                end
                ADD: begin
                    acc    <= acc_step;
                    mcand  <= mcand_step;
                    mplier <= mplier_step;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        result   <= acc_step[WIDTH-1:0];
                        overflow <= |acc_step[2*WIDTH-1:WIDTH];
                        rem_err  <= rem_err_pend;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
